// File: rtl/router_fsm_if.sv
// Router input-port / FIFO-side signal bundle for the packet-sequencing controller.
// master = source and FIFO side, slave = router_fsm.
interface router_fsm_if;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned FIFO_N = 3;

  logic              pkt_valid;
  logic [DATA_W-1:0] data_in;
  logic [FIFO_N-1:0] fifo_full;
  logic [FIFO_N-1:0] fifo_empty;
  logic [FIFO_N-1:0] read_enb;
  logic              busy;
  logic [FIFO_N-1:0] write_enb;
  logic [DATA_W-1:0] dout;
  logic              lfd_state;
  logic [FIFO_N-1:0] soft_reset;
  logic [FIFO_N-1:0] vld_out;
  logic              err;

  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
    input  busy, write_enb, dout, lfd_state, soft_reset, vld_out, err
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty, read_enb,
    output busy, write_enb, dout, lfd_state, soft_reset, vld_out, err
  );
endinterface

// File: rtl/router_fsm.sv
// Packet-sequencing controller: decodes headers, steers bytes into one of three FIFOs,
// checks parity/length and soft-resets FIFOs whose reader stalls for TIMEOUT cycles.
module router_fsm #(
  parameter int unsigned TIMEOUT = 30
) (
  input logic        clock,
  input logic        reset,
  router_fsm_if.slave bus
);
  localparam int unsigned DATA_W = 8;
  localparam int unsigned FIFO_N = 3;
  localparam int unsigned LEN_W  = 6;
  localparam int unsigned PAY_W  = 7;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [2:0] {DA, WTE, LFD, LD, CP, DROP} state_t;

  state_t            state;
  logic [DATA_W-1:0] hdr_reg;
  logic [DATA_W-1:0] par_acc;
  logic [DATA_W-1:0] rx_par;
  logic [1:0]        addr;
  logic [LEN_W-1:0]  len;
  logic [PAY_W-1:0]  pay_cnt;
  logic [FIFO_N-1:0] soft_reset_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt [FIFO_N];

  // Flags extended to 4 entries so an address of 3 reads back as 0.
  logic [3:0] full_x, empty_x, sr_x;
  logic [1:0] hdr_addr;
  logic       full_sel, empty_sel, abort, wr;

  assign full_x    = {1'b0, bus.fifo_full};
  assign empty_x   = {1'b0, bus.fifo_empty};
  assign sr_x      = {1'b0, soft_reset_q};
  assign hdr_addr  = bus.data_in[1:0];
  assign full_sel  = full_x[addr];
  assign empty_sel = empty_x[addr];
  assign abort     = sr_x[addr];

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= DA;
      hdr_reg      <= '0;
      par_acc      <= '0;
      rx_par       <= '0;
      addr         <= '0;
      len          <= '0;
      pay_cnt      <= '0;
      soft_reset_q <= '0;
      err_q        <= 1'b0;
      for (int k = 0; k < FIFO_N; k++) cnt[k] <= '0;
    end else begin
      case (state)
        DA: if (bus.pkt_valid) begin
          if (hdr_addr == 2'd3) begin
            state <= DROP;
            err_q <= 1'b1;
          end else begin
            hdr_reg <= bus.data_in;
            addr    <= hdr_addr;
            len     <= bus.data_in[7:2];
            par_acc <= bus.data_in;
            pay_cnt <= '0;
            state   <= empty_x[hdr_addr] ? LFD : WTE;
          end
        end
        WTE: if (empty_sel) state <= LFD;
        LFD: begin
          if (abort) begin
            state <= DROP;
            err_q <= 1'b1;
          end else begin
            state <= LD;
            err_q <= 1'b0;
          end
        end
        LD: begin
          if (abort) begin
            state <= DROP;
            err_q <= 1'b1;
          end else if (!full_sel) begin
            if (bus.pkt_valid) begin
              par_acc <= par_acc ^ bus.data_in;
              if (pay_cnt != {PAY_W{1'b1}}) pay_cnt <= pay_cnt + PAY_W'(1);
            end else begin
              rx_par <= bus.data_in;
              state  <= CP;
            end
          end
        end
        CP: begin
          err_q <= (par_acc != rx_par) || (pay_cnt != {1'b0, len}) || (len == '0);
          state <= DA;
        end
        DROP: if (!bus.pkt_valid) state <= DA;
        default: state <= DA;
      endcase

      // Per-FIFO stall watchdog: a stalled reader flushes its FIFO after TIMEOUT cycles.
      for (int k = 0; k < FIFO_N; k++) begin
        if (!bus.fifo_empty[k] && !bus.read_enb[k]) begin
          if (cnt[k] == CNT_W'(TIMEOUT - 1)) begin
            soft_reset_q[k] <= 1'b1;
            cnt[k]          <= '0;
          end else begin
            soft_reset_q[k] <= 1'b0;
            cnt[k]          <= cnt[k] + CNT_W'(1);
          end
        end else begin
          soft_reset_q[k] <= 1'b0;
          cnt[k]          <= '0;
        end
      end
    end
  end

  assign wr            = (state == LFD) || ((state == LD) && !full_sel);
  assign bus.busy      = (state == WTE) || (state == LFD) || (state == CP) ||
                         ((state == LD) && full_sel);
  assign bus.write_enb = wr ? FIFO_N'(4'b0001 << addr) : '0;
  assign bus.dout      = (state == LFD) ? hdr_reg :
                         (state == LD)  ? bus.data_in : '0;
  assign bus.lfd_state = (state == LFD);
  assign bus.soft_reset = soft_reset_q;
  assign bus.err        = err_q;
  assign bus.vld_out    = ~bus.fifo_empty;
endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: expected FIFO writes are queued as bytes are driven
// and matched against every observed write strobe.
module tb_router_fsm;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  router_fsm_if bus();
  router_fsm #(.TIMEOUT(30)) dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [1:0] f;
    logic [7:0] d;
    logic       l;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Outputs settle after the inputs change at posedge+1; write events are taken at negedge.
  always @(negedge clock) begin
    exp_t       e;
    logic [2:0] we;
    if (!reset && bus.write_enb !== 3'b000) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL write_unexpected: write_enb=%b dout=%h lfd=%b, expected no write",
                 bus.write_enb, bus.dout, bus.lfd_state);
      end else begin
        e  = exp_q.pop_front();
        we = 3'(4'b0001 << e.f);
        if ({bus.write_enb, bus.dout, bus.lfd_state} !== {we, e.d, e.l}) begin
          failures++;
          $display("FAIL write_data: write_enb=%b dout=%h lfd=%b, expected %b %h %b",
                   bus.write_enb, bus.dout, bus.lfd_state, we, e.d, e.l);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Present a byte and hold it until the DUT accepts it on a non-busy edge.
  task automatic send_byte(input logic pv, input logic [7:0] d);
    int n = 0;
    bus.pkt_valid = pv;
    bus.data_in   = d;
    @(negedge clock);
    while (bus.busy && n < 64) begin
      @(negedge clock);
      n++;
    end
    if (bus.busy) begin
      checks++;
      failures++;
      $display("FAIL busy_timeout: busy=%b after %0d cycles, expected 0", bus.busy, n);
    end
    @(posedge clock); #1;
  endtask

  task automatic push(input logic [1:0] f, input logic [7:0] d, input logic l);
    exp_t e;
    e.f = f; e.d = d; e.l = l;
    exp_q.push_back(e);
  endtask

  task automatic send_pkt3(input logic [7:0] h, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] par);
    if (h[1:0] != 2'd3) begin
      push(h[1:0], h, 1'b1);
      push(h[1:0], b0, 1'b0);
      push(h[1:0], b1, 1'b0);
      push(h[1:0], b2, 1'b0);
      push(h[1:0], par, 1'b0);
    end
    send_byte(1'b1, h);
    send_byte(1'b1, b0);
    send_byte(1'b1, b1);
    send_byte(1'b1, b2);
    send_byte(1'b0, par);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.pkt_valid  = 1'b0;
    bus.data_in    = 8'h00;
    bus.fifo_full  = 3'b000;
    bus.fifo_empty = 3'b101;
    bus.read_enb   = 3'b000;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({bus.busy, bus.write_enb, bus.dout, bus.lfd_state, bus.soft_reset, bus.err} !== 17'b0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b we=%b dout=%h lfd=%b sr=%b err=%b, expected all 0",
               bus.busy, bus.write_enb, bus.dout, bus.lfd_state, bus.soft_reset, bus.err);
    end
    checks++;
    if (bus.vld_out !== 3'b010) begin
      failures++;
      $display("FAIL reset_vld_out: vld_out=%b, expected 010", bus.vld_out);
    end
    bus.fifo_empty = 3'b111;
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_good_packet();
    send_pkt3(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL good_cp_busy: busy=%b, expected 1", bus.busy);
    end
    @(posedge clock); #1;
    checks++;
    if (bus.err !== 1'b0) begin
      failures++;
      $display("FAIL good_err: err=%b, expected 0", bus.err);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL good_drain: %0d writes missing, expected 0", exp_q.size());
    end
  endtask

  task automatic test_bad_parity();
    send_pkt3(8'h0D, 8'h11, 8'h22, 8'h33, 8'h00);
    checks++;
    if (bus.err !== 1'b0) begin
      failures++;
      $display("FAIL bad_err_early: err=%b in CP cycle, expected 0", bus.err);
    end
    @(posedge clock); #1;
    checks++;
    if (bus.err !== 1'b1) begin
      failures++;
      $display("FAIL bad_err: err=%b, expected 1", bus.err);
    end
    // Back-to-back good packet: err clears on its header write.
    push(2'd1, 8'h0D, 1'b1);
    push(2'd1, 8'h11, 1'b0);
    push(2'd1, 8'h22, 1'b0);
    push(2'd1, 8'h33, 1'b0);
    push(2'd1, 8'h0D, 1'b0);
    send_byte(1'b1, 8'h0D);
    bus.data_in = 8'h11;
    checks++;
    if ({bus.lfd_state, bus.err} !== 2'b11) begin
      failures++;
      $display("FAIL bad_lfd_err_hold: lfd=%b err=%b, expected 1 1", bus.lfd_state, bus.err);
    end
    @(posedge clock); #1;
    checks++;
    if (bus.err !== 1'b0) begin
      failures++;
      $display("FAIL bad_err_clear: err=%b after LFD, expected 0", bus.err);
    end
    send_byte(1'b1, 8'h11);
    send_byte(1'b1, 8'h22);
    send_byte(1'b1, 8'h33);
    send_byte(1'b0, 8'h0D);
    @(posedge clock); #1;
    checks++;
    if (bus.err !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL bad_followup: err=%b pending=%0d, expected 0 0", bus.err, exp_q.size());
    end
  endtask

  task automatic test_full_stall();
    push(2'd1, 8'h0D, 1'b1);
    push(2'd1, 8'h11, 1'b0);
    push(2'd1, 8'h22, 1'b0);
    push(2'd1, 8'h33, 1'b0);
    push(2'd1, 8'h0D, 1'b0);
    send_byte(1'b1, 8'h0D);
    send_byte(1'b1, 8'h11);
    bus.fifo_full = 3'b010;
    bus.data_in   = 8'h22;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (bus.busy !== 1'b1 || bus.write_enb !== 3'b000) begin
        failures++;
        $display("FAIL full_stall_%0d: busy=%b we=%b, expected 1 000", i, bus.busy, bus.write_enb);
      end
      @(posedge clock); #1;
    end
    bus.fifo_full = 3'b000;
    send_byte(1'b1, 8'h22);
    send_byte(1'b1, 8'h33);
    send_byte(1'b0, 8'h0D);
    @(posedge clock); #1;
    checks++;
    if (bus.err !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL full_result: err=%b pending=%0d, expected 0 0", bus.err, exp_q.size());
    end
  endtask

  task automatic test_wte();
    bus.fifo_empty = 3'b011;
    bus.read_enb   = 3'b100;
    push(2'd2, 8'h06, 1'b1);
    push(2'd2, 8'h55, 1'b0);
    push(2'd2, 8'h53, 1'b0);
    send_byte(1'b1, 8'h06);
    bus.data_in = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if ({bus.busy, bus.lfd_state, bus.write_enb} !== 5'b10000) begin
        failures++;
        $display("FAIL wte_wait_%0d: busy=%b lfd=%b we=%b, expected 1 0 000",
                 i, bus.busy, bus.lfd_state, bus.write_enb);
      end
      @(posedge clock); #1;
    end
    bus.fifo_empty = 3'b111;
    @(posedge clock); #1;
    checks++;
    if ({bus.lfd_state, bus.write_enb, bus.dout} !== {1'b1, 3'b100, 8'h06}) begin
      failures++;
      $display("FAIL wte_lfd: lfd=%b we=%b dout=%h, expected 1 100 06",
               bus.lfd_state, bus.write_enb, bus.dout);
    end
    send_byte(1'b1, 8'h55);
    send_byte(1'b0, 8'h53);
    @(posedge clock); #1;
    bus.read_enb = 3'b000;
    checks++;
    if (bus.err !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL wte_result: err=%b pending=%0d, expected 0 0", bus.err, exp_q.size());
    end
  endtask

  task automatic test_timeout();
    int pulses, first_at, other;
    bus.pkt_valid  = 1'b0;
    bus.read_enb   = 3'b000;
    bus.fifo_empty = 3'b110;
    pulses = 0; first_at = 0; other = 0;
    for (int i = 1; i <= 35; i++) begin
      @(posedge clock); #1;
      if (bus.soft_reset[0]) begin
        pulses++;
        if (first_at == 0) first_at = i;
      end
      if (bus.soft_reset[2:1] != 2'b00) other++;
    end
    checks++;
    if (pulses != 1 || first_at != 30 || other != 0) begin
      failures++;
      $display("FAIL timeout_plain: pulses=%0d at=%0d other=%0d, expected 1 30 0",
               pulses, first_at, other);
    end
    bus.fifo_empty = 3'b111;
    @(posedge clock); #1;
    bus.fifo_empty = 3'b110;
    pulses = 0; first_at = 0;
    for (int i = 1; i <= 50; i++) begin
      bus.read_enb = (i == 15) ? 3'b001 : 3'b000;
      @(posedge clock); #1;
      if (bus.soft_reset[0]) begin
        pulses++;
        if (first_at == 0) first_at = i;
      end
    end
    bus.read_enb = 3'b000;
    checks++;
    if (pulses != 1 || first_at != 45) begin
      failures++;
      $display("FAIL timeout_read_pulse: pulses=%0d at=%0d, expected 1 45", pulses, first_at);
    end
    bus.fifo_empty = 3'b111;
    @(posedge clock); #1;
  endtask

  task automatic test_drop();
    send_byte(1'b1, 8'h07);
    checks++;
    if ({bus.err, bus.busy} !== 2'b10) begin
      failures++;
      $display("FAIL drop_entry: err=%b busy=%b, expected 1 0", bus.err, bus.busy);
    end
    send_byte(1'b1, 8'hAA);
    send_byte(1'b1, 8'hBB);
    send_byte(1'b0, 8'h00);
    checks++;
    if ({bus.err, bus.busy, bus.write_enb} !== 5'b10000) begin
      failures++;
      $display("FAIL drop_exit: err=%b busy=%b we=%b, expected 1 0 000",
               bus.err, bus.busy, bus.write_enb);
    end
    send_pkt3(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D);
    @(posedge clock); #1;
    checks++;
    if (bus.err !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL drop_recover: err=%b pending=%0d, expected 0 0", bus.err, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_ld();
    push(2'd1, 8'h0D, 1'b1);
    push(2'd1, 8'h11, 1'b0);
    send_byte(1'b1, 8'h0D);
    send_byte(1'b1, 8'h11);
    bus.data_in = 8'h22;
    reset = 1'b1;
    @(posedge clock); #1;
    checks++;
    if ({bus.busy, bus.write_enb, bus.dout, bus.lfd_state, bus.soft_reset, bus.err} !== 17'b0) begin
      failures++;
      $display("FAIL midreset_outputs: busy=%b we=%b dout=%h lfd=%b sr=%b err=%b, expected all 0",
               bus.busy, bus.write_enb, bus.dout, bus.lfd_state, bus.soft_reset, bus.err);
    end
    reset = 1'b0;
    bus.pkt_valid = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (bus.busy !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL midreset_idle: busy=%b pending=%0d, expected 0 0", bus.busy, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_bad_parity();
    test_full_stall();
    test_wte();
    test_timeout();
    test_drop();
    test_reset_mid_ld();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
